iq_power_meter: RTL and testbench
=================================

Name: iq_power_meter

Overview:
- Sits directly downstream of the real/imag IIR filter pair and consumes their y_real/y_imag outputs and the filter output strobe.
- Computes instantaneous power I²+Q² per valid sample and averages it over fixed windows of 2^LOG2N valid samples.
- Emits one averaged power word per window, with a one-cycle strobe, for ILA capture and for measuring filter response during the frequency sweep.

Parameters:
- DW, 18, signed input sample width (matches filter d_out).
- LOG2N, 10, log2 of window length in valid samples; legal range 1..16.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- dv_in  in  1  input sample valid (driven by the filter dv_out).
- i_in  in  DW  signed real sample.
- q_in  in  DW  signed imag sample.
- clear  in  1  synchronous window restart.
- pwr_valid  out  1  one-cycle strobe: window result valid.
- pwr_out  out  2*DW  unsigned window-average power.
- peak_out  out  2*DW  unsigned per-window peak instantaneous power.
- win_cnt  out  16  completed-window counter; wraps 0xFFFF→0.

Behaviour:
- Reset (async, any time, including mid-window):
  - pwr_valid=0, pwr_out=0, peak_out=0, win_cnt=0.
  - Accumulator, sample counter and all pipeline valid bits cleared; effect is immediate, not clock-gated.
- Pipeline (no backpressure; dv_in accepted on every edge where it is 1):
  - Edge E samples dv_in=1. Squares i_in², q_in² are registered as 2*DW-1-bit unsigned values; max is (−2^(DW−1))² = 2^(2DW−2).
  - Edge E+1: sum s=i²+q² registered, 2*DW bits unsigned, cannot overflow.
  - Edge E+2: s is added to the accumulator (2*DW+LOG2N bits, exact, no overflow possible) and the sample counter is incremented.
- Window close:
  - When the counter reaches 2^LOG2N−1 and a sample arrives at E+2, then at edge E+2:
    - pwr_out ← (acc+s)>>LOG2N, floor truncation.
    - pwr_valid←1 for exactly one cycle.
    - win_cnt increments.
    - Accumulator and counter reset to 0, so the next window starts seamlessly with no lost sample.
  - pwr_valid rises 3 edges after the edge sampling the last input (counting that edge).
  - pwr_out and peak_out hold their values until the next window close.
- Gaps in dv_in: pipeline stages advance only with their own valid bits, so idle cycles add nothing. Back-to-back dv_in every cycle is supported.
- clear:
  - On an edge with clear=1: accumulator, counter and peak tracker are zeroed and all in-flight pipeline valid bits are dropped (those samples are discarded).
  - pwr_out, peak_out and win_cnt are not changed.
  - No pwr_valid is generated from the partial window.
  - If clear and dv_in are both 1 on the same edge, clear wins and that sample is discarded.
  - If clear occurs on the window-closing edge, clear wins: no strobe, no update.
- States (implicit in counter): FILL (counter 0..N−2), CLOSE (last sample at E+2). Transitions are driven only by pipelined valid.

Optional Feature:
- Macro IQ_POWER_METER_PEAK_EN.
- Defined:
  - A running max of s is tracked per window, loaded from the first sample of each window.
  - At window close, peak_out ← max(running, s).
  - Peak tracker is cleared by clear/rst.
- Undefined: no peak logic is built and peak_out is tied to 0.

Test Plan (DW=18, LOG2N=4, N=16):
- Constant window: 16 samples, I=1000, Q=0, dv_in every cycle → one pwr_valid 3 edges after the 16th sample; pwr_out=1000000; peak_out=1000000 (PEAK_EN); win_cnt=1.
- Full scale: I=Q=−131072 for 16 samples → pwr_out=2^35=34359738368, no overflow; peak_out=2^35.
- Gapped input: 16 samples I=3, Q=4 with dv_in toggled with random idle gaps → exactly one pwr_valid; pwr_out=25.
- Truncation: alternate I=3 and I=0 (Q=0) over 16 samples → sum 72, pwr_out=4; peak_out=9.
- clear mid-window: 10 samples of I=500, then clear asserted together with a dv_in sample, then 16 samples I=100, Q=0 → no strobe for the partial window; a single strobe with pwr_out=10000.
- Async reset: assert rst between clock edges mid-window after a prior result → pwr_out, peak_out, win_cnt and pwr_valid are 0 immediately. After release, 16 samples I=Q=10 → pwr_out=200, win_cnt=1.

Source files
------------

// File: rtl/iq_power_meter_if.sv
// iq_power_meter_if: sample input and window-result bundle for iq_power_meter.
interface iq_power_meter_if #(parameter int DW = 18);
    logic                 dv_in;
    logic signed [DW-1:0] i_in;
    logic signed [DW-1:0] q_in;
    logic                 clear;
    logic                 pwr_valid;
    logic [2*DW-1:0]      pwr_out;
    logic [2*DW-1:0]      peak_out;
    logic [15:0]          win_cnt;
    modport master (output dv_in, i_in, q_in, clear, input pwr_valid, pwr_out, peak_out, win_cnt);
    modport slave  (input dv_in, i_in, q_in, clear, output pwr_valid, pwr_out, peak_out, win_cnt);
endinterface

// File: rtl/iq_power_meter.sv
// iq_power_meter: windowed average of I^2+Q^2 over 2^LOG2N valid samples.
// Define IQ_POWER_METER_PEAK_EN to build the per-window peak tracker.
module iq_power_meter #(
    parameter int DW    = 18,
    parameter int LOG2N = 10
) (
    input logic             clk,
    input logic             rst,
    iq_power_meter_if.slave bus
);
    localparam int AW = 2*DW + LOG2N;
    logic                   v1, v2, pv, close;
    logic signed [2*DW-1:0] ip, qp;
    logic [2*DW-2:0]        isq, qsq;
    logic [2*DW-1:0]        s, pwr;
    logic [AW-1:0]          acc, acc_sum;
    logic [LOG2N-1:0]       cnt;
    logic [15:0]            wc;
    always_comb begin
        ip      = bus.i_in * bus.i_in;
        qp      = bus.q_in * bus.q_in;
        acc_sum = acc + AW'(s);
        close   = v2 & (&cnt) & ~bus.clear;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            pv  <= 1'b0;
            isq <= '0;
            qsq <= '0;
            s   <= '0;
            acc <= '0;
            cnt <= '0;
            pwr <= '0;
            wc  <= '0;
        end else begin
            v1 <= bus.dv_in & ~bus.clear;
            v2 <= v1 & ~bus.clear;
            pv <= close;
            if (bus.dv_in) begin
                isq <= ip[2*DW-2:0];
                qsq <= qp[2*DW-2:0];
            end
            if (v1)
                s <= {1'b0, isq} + {1'b0, qsq};
            if (bus.clear) begin
                acc <= '0;
                cnt <= '0;
            end else if (v2) begin
                acc <= close ? '0 : acc_sum;
                cnt <= cnt + 1'b1;
            end
            if (close) begin
                pwr <= acc_sum[AW-1:LOG2N];
                wc  <= wc + 1'b1;
            end
        end
    end
    assign bus.pwr_valid = pv;
    assign bus.pwr_out   = pwr;
    assign bus.win_cnt   = wc;
`ifdef IQ_POWER_METER_PEAK_EN
    logic [2*DW-1:0] pk_run, pk_next, pk;
    // first sample of a window reloads the running max
    always_comb pk_next = (cnt == '0 || s > pk_run) ? s : pk_run;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pk_run <= '0;
            pk     <= '0;
        end else begin
            if (bus.clear)
                pk_run <= '0;
            else if (v2)
                pk_run <= pk_next;
            if (close)
                pk <= pk_next;
        end
    end
    assign bus.peak_out = pk;
`else
    assign bus.peak_out = '0;
`endif
endmodule

// File: tb/tb_iq_power_meter.sv
// tb_iq_power_meter: directed checks of iq_power_meter with DW=18, LOG2N=4.
module tb_iq_power_meter;
    localparam int DW = 18;
`ifdef IQ_POWER_METER_PEAK_EN
    localparam bit PK = 1'b1;
`else
    localparam bit PK = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    iq_power_meter_if #(.DW(DW)) bus();
    iq_power_meter #(.DW(DW), .LOG2N(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int nstrobe = 0;
    logic [2*DW-1:0] rec_p [64];
    logic [2*DW-1:0] rec_k [64];

    always @(posedge clk) begin
        #1;
        if (bus.pwr_valid && nstrobe < 64) begin
            rec_p[nstrobe] = bus.pwr_out;
            rec_k[nstrobe] = bus.peak_out;
            nstrobe = nstrobe + 1;
        end
    end

    function automatic logic [2*DW-1:0] pk_exp(input logic [2*DW-1:0] x);
        return PK ? x : '0;
    endfunction

    task automatic smp(input int i, input int q);
        @(negedge clk);
        bus.dv_in = 1'b1;
        bus.i_in  = DW'(i);
        bus.q_in  = DW'(q);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.dv_in = 1'b0;
        end
    endtask

    task automatic chk_result(input string name, input int base, input int nexp,
                              input logic [2*DW-1:0] p, input logic [2*DW-1:0] k,
                              input logic [15:0] w);
        checks++;
        if (nstrobe - base !== nexp) begin
            failures++;
            $display("FAIL %s strobes: got %0d want %0d", name, nstrobe - base, nexp);
        end
        checks++;
        if (bus.pwr_out !== p) begin
            failures++;
            $display("FAIL %s pwr_out: got %0d want %0d", name, bus.pwr_out, p);
        end
        checks++;
        if (bus.peak_out !== pk_exp(k)) begin
            failures++;
            $display("FAIL %s peak_out: got %0d want %0d", name, bus.peak_out, pk_exp(k));
        end
        checks++;
        if (bus.win_cnt !== w) begin
            failures++;
            $display("FAIL %s win_cnt: got %0d want %0d", name, bus.win_cnt, w);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({bus.pwr_valid, bus.pwr_out, bus.peak_out, bus.win_cnt} !== '0) begin
            failures++;
            $display("FAIL reset outputs: got v=%b p=%0d k=%0d w=%0d want all 0",
                     bus.pwr_valid, bus.pwr_out, bus.peak_out, bus.win_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_constant();
        int base = nstrobe;
        logic exp_v [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int n = 0; n < 16; n++) smp(1000, 0);
        for (int e = 0; e < 4; e++) begin
            @(posedge clk);
            #1;
            bus.dv_in = 1'b0;
            checks++;
            if (bus.pwr_valid !== exp_v[e]) begin
                failures++;
                $display("FAIL latency edge E+%0d pwr_valid: got %b want %b", e, bus.pwr_valid, exp_v[e]);
            end
        end
        idle(3);
        chk_result("constant", base, 1, 36'd1000000, 36'd1000000, 16'd1);
    endtask

    task automatic test_full_scale();
        int base = nstrobe;
        for (int n = 0; n < 16; n++) smp(-131072, -131072);
        idle(6);
        chk_result("full_scale", base, 1, 36'd34359738368, 36'd34359738368, 16'd2);
    endtask

    task automatic test_gapped();
        int base = nstrobe;
        for (int n = 0; n < 16; n++) begin
            smp(3, 4);
            idle($urandom_range(0, 3));
        end
        idle(6);
        chk_result("gapped", base, 1, 36'd25, 36'd25, 16'd3);
    endtask

    task automatic test_truncation();
        int base = nstrobe;
        for (int n = 0; n < 16; n++) smp((n % 2 == 0) ? 3 : 0, 0);
        idle(6);
        chk_result("truncation", base, 1, 36'd4, 36'd9, 16'd4);
    endtask

    task automatic test_back_to_back();
        int base = nstrobe;
        for (int n = 0; n < 32; n++) smp(n < 16 ? 2 : 4, 0);
        idle(6);
        chk_result("back_to_back", base, 2, 36'd16, 36'd16, 16'd6);
        checks++;
        if (rec_p[base] !== 36'd4 || rec_k[base] !== pk_exp(36'd4)) begin
            failures++;
            $display("FAIL back_to_back first window: got p=%0d k=%0d want p=4 k=%0d",
                     rec_p[base], rec_k[base], pk_exp(36'd4));
        end
    endtask

    task automatic test_clear();
        int base = nstrobe;
        for (int n = 0; n < 10; n++) smp(500, 0);
        @(negedge clk);
        bus.clear = 1'b1;
        bus.dv_in = 1'b1;
        bus.i_in  = 18'sd500;
        @(negedge clk);
        bus.clear = 1'b0;
        bus.dv_in = 1'b0;
        checks++;
        if (bus.pwr_out !== 36'd16 || bus.win_cnt !== 16'd6) begin
            failures++;
            $display("FAIL clear hold: got p=%0d w=%0d want p=16 w=6", bus.pwr_out, bus.win_cnt);
        end
        for (int n = 0; n < 16; n++) smp(100, 0);
        idle(6);
        chk_result("clear", base, 1, 36'd10000, 36'd10000, 16'd7);
    endtask

    task automatic test_async_reset();
        int base;
        for (int n = 0; n < 5; n++) smp(10, 10);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.pwr_valid, bus.pwr_out, bus.peak_out, bus.win_cnt} !== '0) begin
            failures++;
            $display("FAIL async_reset outputs: got v=%b p=%0d k=%0d w=%0d want all 0",
                     bus.pwr_valid, bus.pwr_out, bus.peak_out, bus.win_cnt);
        end
        @(negedge clk);
        bus.dv_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        base = nstrobe;
        for (int n = 0; n < 16; n++) smp(10, 10);
        idle(6);
        chk_result("after_reset", base, 1, 36'd200, 36'd200, 16'd1);
    endtask

    initial begin
        bus.dv_in = 1'b0;
        bus.i_in  = '0;
        bus.q_in  = '0;
        bus.clear = 1'b0;
        test_reset();
        test_constant();
        test_full_scale();
        test_gapped();
        test_truncation();
        test_back_to_back();
        test_clear();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
